cvxif_offload_issuer: RTL and testbench

CVXIF_OFFLOAD_ISSUER -- requirements
Module: cvxif_offload_issuer

---
 rtl/cvxif_issuer_pkg.sv | 19 +
 rtl/cvxif_result_timer.sv | 27 ++
 rtl/cvxif_offload_issuer.sv | 201 ++++++++++++++++++++
 tb/tb_cvxif_offload_issuer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_issuer_pkg.sv
// Shared types for the CV-X-IF offload issuer: FSM state encoding and the
// coprocessor issue-response bundle.
package cvxif_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_RESULT = 2'd2,
        DONE        = 2'd3
    } issuer_state_t;

    // Field order matches the coprocessor-side definition.
    typedef struct packed {
        logic       accept;
        logic       writeback;
        logic [2:0] register_read;
    } issue_resp_t;

endpackage

// File: rtl/cvxif_result_timer.sv
// WAIT_RESULT watchdog: counts cycles while active and flags the TIMEOUT-th
// active cycle. Only instantiated when CVXIF_ISSUER_TIMEOUT_EN is defined.
module cvxif_result_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    // Holds at zero whenever inactive, so every WAIT_RESULT entry starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || !active_i) begin
            count_q <= '0;
        end else if (!expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = active_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cvxif_offload_issuer.sv
// Single-outstanding CV-X-IF offload issuer: accepts one instruction from the
// core, issues it, waits for its result and reports completion.
// Optional WAIT_RESULT timeout enabled by defining CVXIF_ISSUER_TIMEOUT_EN.
module cvxif_offload_issuer
    import cvxif_issuer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   rs3_i,

    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output logic [31:0]       issue_instr_o,
    output logic [ID_W-1:0]   issue_id_o,
    output logic [3*XLEN-1:0] issue_rs_o,
    output logic [2:0]        issue_rs_valid_o,

    input  logic              issue_accept_i,
    input  logic              issue_writeback_i,
    input  logic [2:0]        issue_register_read_i,

    input  logic              result_valid_i,
    output logic              result_ready_o,
    input  logic [ID_W-1:0]   result_id_i,
    input  logic [XLEN-1:0]   result_data_i,
    input  logic [4:0]        result_rd_i,
    input  logic              result_we_i,

    output logic              done_valid_o,
    input  logic              done_ready_i,
    output logic [XLEN-1:0]   done_data_o,
    output logic [4:0]        done_rd_o,
    output logic              done_we_o,
    output logic              done_illegal_o,
    output logic              done_timeout_o,
    output logic              busy_o
);

    issuer_state_t state_q, state_d;
    issue_resp_t   resp;

    logic [31:0]       instr_q;
    logic [ID_W-1:0]   id_q;
    logic [3*XLEN-1:0] rs_q;
    logic              wb_q;
    logic [XLEN-1:0]   data_q;
    logic [4:0]        rd_q;
    logic              we_q;
    logic              illegal_q;

    logic instr_hs;
    logic issue_hs;
    logic result_hit;
    logic timed_out;
    logic timer_expired;

    assign resp = '{accept:        issue_accept_i,
                    writeback:     issue_writeback_i,
                    register_read: issue_register_read_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        instr_ready_o  = 1'b0;
        issue_valid_o  = 1'b0;
        result_ready_o = 1'b0;
        done_valid_o   = 1'b0;
        instr_hs       = 1'b0;
        issue_hs       = 1'b0;
        result_hit     = 1'b0;
        timed_out      = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready_o = !rst_i;
                instr_hs      = instr_valid_i;
                if (instr_valid_i) state_d = ISSUE;
            end
            ISSUE: begin
                issue_valid_o = 1'b1;
                issue_hs      = issue_ready_i;
                if (issue_ready_i) state_d = resp.accept ? WAIT_RESULT : DONE;
            end
            WAIT_RESULT: begin
                result_ready_o = 1'b1;
                result_hit     = result_valid_i && (result_id_i == id_q);
                // A matching result in the expiry cycle takes priority.
                timed_out      = !result_hit && timer_expired;
                if (result_hit || timed_out) state_d = DONE;
            end
            DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields latch on acceptance; completion fields are cleared then so
    // each transaction reports only its own outcome.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q   <= '0;
            id_q      <= '0;
            rs_q      <= '0;
            wb_q      <= 1'b0;
            data_q    <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (instr_hs) begin
                instr_q   <= instr_i;
                id_q      <= id_i;
                rs_q      <= {rs3_i, rs2_i, rs1_i};
                wb_q      <= 1'b0;
                data_q    <= '0;
                rd_q      <= '0;
                we_q      <= 1'b0;
                illegal_q <= 1'b0;
            end
            if (issue_hs) begin
                if (resp.accept) begin
                    wb_q <= resp.writeback;
                end else begin
                    illegal_q <= 1'b1;
                    we_q      <= 1'b0;
                end
            end
            if (result_hit) begin
                data_q <= result_data_i;
                rd_q   <= result_rd_i;
                we_q   <= result_we_i & wb_q;
            end
            if (timed_out) begin
                we_q <= 1'b0;
            end
        end
    end

`ifdef CVXIF_ISSUER_TIMEOUT_EN
    logic timeout_q;

    cvxif_result_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (state_q == WAIT_RESULT),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || instr_hs) begin
            timeout_q <= 1'b0;
        end else if (timed_out) begin
            timeout_q <= 1'b1;
        end
    end

    assign done_timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign timer_expired  = 1'b0;
    assign done_timeout_o = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // The issuer always supplies all three operands, so register_read is moot.
    logic unused_resp;
    assign unused_resp = ^resp.register_read;

    assign issue_instr_o    = instr_q;
    assign issue_id_o       = id_q;
    assign issue_rs_o       = rs_q;
    assign issue_rs_valid_o = {3{state_q == ISSUE}};
    assign done_data_o      = data_q;
    assign done_rd_o        = rd_q;
    assign done_we_o        = we_q;
    assign done_illegal_o   = illegal_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_cvxif_offload_issuer.sv
// Randomised self-checking bench for cvxif_offload_issuer; the expected
// outcome of each transaction comes from a transaction-level result model.
module tb_cvxif_offload_issuer;

    localparam int XLEN    = 32;
    localparam int ID_W    = 3;
    localparam int TIMEOUT = 8;
`ifdef CVXIF_ISSUER_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              instr_valid_i = 1'b0;
    logic              instr_ready_o;
    logic [31:0]       instr_i = '0;
    logic [ID_W-1:0]   id_i = '0;
    logic [XLEN-1:0]   rs1_i = '0, rs2_i = '0, rs3_i = '0;
    logic              issue_valid_o;
    logic              issue_ready_i = 1'b0;
    logic [31:0]       issue_instr_o;
    logic [ID_W-1:0]   issue_id_o;
    logic [3*XLEN-1:0] issue_rs_o;
    logic [2:0]        issue_rs_valid_o;
    logic              issue_accept_i = 1'b0;
    logic              issue_writeback_i = 1'b0;
    logic [2:0]        issue_register_read_i = '0;
    logic              result_valid_i = 1'b0;
    logic              result_ready_o;
    logic [ID_W-1:0]   result_id_i = '0;
    logic [XLEN-1:0]   result_data_i = '0;
    logic [4:0]        result_rd_i = '0;
    logic              result_we_i = 1'b0;
    logic              done_valid_o;
    logic              done_ready_i = 1'b0;
    logic [XLEN-1:0]   done_data_o;
    logic [4:0]        done_rd_o;
    logic              done_we_o;
    logic              done_illegal_o;
    logic              done_timeout_o;
    logic              busy_o;

    cvxif_offload_issuer #(
        .XLEN    (XLEN),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .instr_i               (instr_i),
        .id_i                  (id_i),
        .rs1_i                 (rs1_i),
        .rs2_i                 (rs2_i),
        .rs3_i                 (rs3_i),
        .issue_valid_o         (issue_valid_o),
        .issue_ready_i         (issue_ready_i),
        .issue_instr_o         (issue_instr_o),
        .issue_id_o            (issue_id_o),
        .issue_rs_o            (issue_rs_o),
        .issue_rs_valid_o      (issue_rs_valid_o),
        .issue_accept_i        (issue_accept_i),
        .issue_writeback_i     (issue_writeback_i),
        .issue_register_read_i (issue_register_read_i),
        .result_valid_i        (result_valid_i),
        .result_ready_o        (result_ready_o),
        .result_id_i           (result_id_i),
        .result_data_i         (result_data_i),
        .result_rd_i           (result_rd_i),
        .result_we_i           (result_we_i),
        .done_valid_o          (done_valid_o),
        .done_ready_i          (done_ready_i),
        .done_data_o           (done_data_o),
        .done_rd_o             (done_rd_o),
        .done_we_o             (done_we_o),
        .done_illegal_o        (done_illegal_o),
        .done_timeout_o        (done_timeout_o),
        .busy_o                (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit              v;
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic [4:0]      rd;
        bit              we;
    } res_t;

    // Per-WAIT_RESULT-cycle result traffic for the current transaction.
    res_t plan[$];

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic addResult(input bit v, input logic [ID_W-1:0] id, input logic [31:0] data,
                             input logic [4:0] rd, input bit we);
        res_t r;
        r.v = v; r.id = id; r.data = data; r.rd = rd; r.we = we;
        plan.push_back(r);
    endtask

    // Which WAIT_RESULT cycle ends the transaction: the first matching result,
    // unless the watchdog (when built in) fires first.
    function automatic int predictFinish(input logic [ID_W-1:0] id, output bit is_timeout);
        int hit = -1;
        foreach (plan[i]) if (hit < 0 && plan[i].v && plan[i].id == id) hit = i + 1;
        is_timeout = 1'b0;
        if (TEN && (hit < 0 || hit > TIMEOUT)) begin
            is_timeout = 1'b1;
            return TIMEOUT;
        end
        return hit;
    endfunction

    task automatic randomPlan(input logic [ID_W-1:0] id, input bit allow_no_match);
        int n = $urandom_range(0, 5);
        plan.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1)
                addResult(1'b1, id ^ ID_W'($urandom_range(1, 7)), $urandom, 5'($urandom), 1'($urandom));
            else
                addResult(1'b0, ID_W'($urandom), $urandom, 5'($urandom), 1'($urandom));
        end
        if (allow_no_match && $urandom_range(0, 2) == 0) begin
            repeat (TIMEOUT) addResult(1'b0, id, $urandom, 5'($urandom), 1'($urandom));
        end else begin
            addResult(1'b1, id, $urandom, 5'($urandom), 1'($urandom));
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [ID_W-1:0] id,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                                 input bit accept, input bit wb,
                                 input int issue_stall, input int done_stall, input int rst_wait);
        int  finish;
        bit  to;
        bit  normal;
        logic [39:0] exp_done;
        logic [34:0] exp_issue;

        exp_issue = {id, instr};
        instr_valid_i = 1'b1; instr_i = instr; id_i = id;
        rs1_i = r1; rs2_i = r2; rs3_i = r3;
        checkOutput("instr_ready_idle", instr_ready_o, 1'b1);
        @(posedge clk_i); @(negedge clk_i);

        for (int s = 0; s <= issue_stall; s++) begin
            instr_valid_i = 1'($urandom); instr_i = $urandom; id_i = ID_W'($urandom);
            rs1_i = $urandom; rs2_i = $urandom; rs3_i = $urandom;
            checkOutput("issue_valid", issue_valid_o, 1'b1);
            checkOutput("issue_id_instr", {issue_id_o, issue_instr_o}, exp_issue);
            checkOutput("issue_rs", issue_rs_o, {r3, r2, r1});
            checkOutput("issue_rs_valid", issue_rs_valid_o, 3'b111);
            checkOutput("issue_flags", {instr_ready_o, result_ready_o, busy_o}, 3'b001);
            if (s < issue_stall) begin
                issue_ready_i = 1'b0;
                issue_accept_i = 1'($urandom); issue_writeback_i = 1'($urandom);
                @(posedge clk_i); @(negedge clk_i);
            end
        end
        issue_ready_i = 1'b1; issue_accept_i = accept; issue_writeback_i = wb;
        issue_register_read_i = 3'($urandom);
        @(posedge clk_i); @(negedge clk_i);
        issue_ready_i = 1'b0; issue_accept_i = 1'($urandom); issue_writeback_i = 1'($urandom);
        instr_valid_i = 1'b0;

        normal = 1'b0;
        exp_done = '0;
        if (!accept) begin
            exp_done = {32'h0, 5'h0, 1'b0, 1'b1, 1'b0};
        end else begin
            finish = predictFinish(id, to);
            for (int w = 1; w <= finish; w++) begin
                checkOutput("wait_ready", {result_ready_o, done_valid_o, issue_valid_o}, 3'b100);
                if (w == rst_wait) begin
                    result_valid_i = 1'b0;
                    rst_i = 1'b1;
                    @(posedge clk_i); @(negedge clk_i);
                    rst_i = 1'b0;
                    #1;
                    checkOutput("rst_abandon", {busy_o, done_valid_o, instr_ready_o}, 3'b001);
                    repeat (3) begin
                        @(posedge clk_i); @(negedge clk_i);
                        checkOutput("rst_no_done", {busy_o, done_valid_o}, 2'b00);
                    end
                    return;
                end
                if (w <= plan.size()) begin
                    result_valid_i = plan[w-1].v; result_id_i = plan[w-1].id;
                    result_data_i = plan[w-1].data; result_rd_i = plan[w-1].rd;
                    result_we_i = plan[w-1].we;
                end else begin
                    result_valid_i = 1'b0; result_id_i = ID_W'($urandom);
                end
                @(posedge clk_i); @(negedge clk_i);
            end
            if (to) begin
                exp_done = {32'h0, 5'h0, 1'b0, 1'b0, 1'b1};
            end else begin
                normal = 1'b1;
                exp_done = {plan[finish-1].data, plan[finish-1].rd,
                            plan[finish-1].we & wb, 1'b0, 1'b0};
            end
        end

        for (int s = 0; s <= done_stall; s++) begin
            result_valid_i = 1'($urandom); result_id_i = id; result_data_i = $urandom;
            instr_valid_i = 1'($urandom);
            checkOutput("done_valid", {done_valid_o, result_ready_o, busy_o, instr_ready_o}, 4'b1010);
            if (normal)
                checkOutput("done_payload", {done_data_o, done_rd_o, done_we_o, done_illegal_o, done_timeout_o}, exp_done);
            else
                checkOutput("done_flags", {done_we_o, done_illegal_o, done_timeout_o}, exp_done[2:0]);
            done_ready_i = (s == done_stall);
            @(posedge clk_i); @(negedge clk_i);
        end
        done_ready_i = 1'b0; result_valid_i = 1'b0; instr_valid_i = 1'b0;
        checkOutput("back_to_idle", {done_valid_o, busy_o, instr_ready_o}, 3'b001);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        checkOutput("reset_outputs",
                    {instr_ready_o, issue_valid_o, result_ready_o, done_valid_o, busy_o,
                     done_we_o, done_illegal_o, done_timeout_o, issue_rs_valid_o}, 11'h0);
        checkOutput("reset_data", {done_data_o, done_rd_o, issue_instr_o}, 69'h0);
        rst_i = 1'b0;
        #1;
        checkOutput("reset_release_ready", instr_ready_o, 1'b1);

        // Scenario 1: plain writeback.
        plan.delete(); addResult(1'b1, 3'd2, 32'd12, 5'd1, 1'b1);
        applyStimulus(32'h003110FB, 3'd2, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1, 0, 0, 0);
        // Scenario 2: writeback mask clears we.
        plan.delete(); addResult(1'b1, 3'd1, 32'hFF, 5'd3, 1'b1);
        applyStimulus(32'h0000007B, 3'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0, 0);
        // Scenario 3: rejected instruction.
        plan.delete();
        applyStimulus(32'h00000033, 3'd5, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 0, 0, 0);
        // Scenario 4: foreign result discarded.
        plan.delete();
        addResult(1'b1, 3'd3, 32'd9, 5'd2, 1'b1);
        addResult(1'b1, 3'd4, 32'd6, 5'd2, 1'b1);
        applyStimulus(32'h0020A0AB, 3'd4, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, 0, 0, 0);
        if (TEN) begin
            // Scenario 5: pure timeout, then a match exactly at the expiry cycle.
            plan.delete();
            repeat (TIMEOUT) addResult(1'b0, 3'd6, 32'd0, 5'd0, 1'b0);
            applyStimulus(32'h0000107B, 3'd6, 32'd1, 32'd1, 32'd1, 1'b1, 1'b1, 0, 0, 0);
            plan.delete();
            repeat (TIMEOUT - 1) addResult(1'b1, 3'd1, $urandom, 5'd4, 1'b1);
            addResult(1'b1, 3'd6, 32'hCAFE, 5'd9, 1'b1);
            applyStimulus(32'h0000207B, 3'd6, 32'd2, 32'd2, 32'd2, 1'b1, 1'b1, 0, 0, 0);
        end
        // Scenario 6: backpressure on both handshakes, then reset while waiting.
        plan.delete(); addResult(1'b0, 3'd0, 0, 0, 0); addResult(1'b1, 3'd7, 32'h1234, 5'd31, 1'b1);
        applyStimulus(32'h7654307B, 3'd7, $urandom, $urandom, $urandom, 1'b1, 1'b1, 5, 3, 0);
        plan.delete();
        repeat (3) addResult(1'b0, 3'd0, 0, 0, 0);
        addResult(1'b1, 3'd3, 32'h55, 5'd5, 1'b1);
        applyStimulus(32'h0000407B, 3'd3, 32'd8, 32'd9, 32'd10, 1'b1, 1'b1, 0, 0, 2);
        plan.delete(); addResult(1'b1, 3'd0, 32'hABCD, 5'd7, 1'b1);
        applyStimulus(32'h0000507B, 3'd0, 32'd4, 32'd4, 32'd4, 1'b1, 1'b1, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            logic [ID_W-1:0] rid;
            rid = ID_W'($urandom);
            randomPlan(rid, TEN);
            applyStimulus($urandom, rid, $urandom, $urandom, $urandom,
                          ($urandom_range(0, 5) != 0), 1'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
